// File: rtl/cpu_bus_seq.sv
// Purpose: sequences one 1..MAX_BEATS-beat core request into 4-phase bus_clk/data_ready beats.
// Latency: 1 cycle to first strobe, then per beat (strobe-high + ack-low) cycles, 1-cycle done pulse.
// Backpressure: i_req is ignored while o_busy; each beat waits on i_bus_data_ready (optional timeout).
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_req .. i_wdata        core request (accepted when i_req & ~o_busy)
//   o_busy, o_done, o_err   request status; o_err qualifies the o_done pulse
//   o_rdata                 assembled read data (little-endian DATA_W slices)
//   o_bus_* / i_bus_*       per-beat strobe, write enable, address, data, acknowledge
module cpu_bus_seq #(
    parameter int  ADDR_W    = 32,
    parameter int  DATA_W    = 8,
    parameter int  MAX_BEATS = 4,
    parameter int  TIMEOUT   = 255,
    localparam int BW        = $clog2(MAX_BEATS + 1)
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_req,
    input  logic                          i_we,
    input  logic                          i_dec,
    input  logic [ADDR_W-1:0]             i_addr,
    input  logic [BW-1:0]                 i_beats,
    input  logic [MAX_BEATS*DATA_W-1:0]   i_wdata,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_err,
    output logic [MAX_BEATS*DATA_W-1:0]   o_rdata,
    output logic                          o_bus_clk,
    output logic                          o_bus_we,
    output logic [ADDR_W-1:0]             o_bus_addr,
    output logic [DATA_W-1:0]             o_bus_data,
    input  logic [DATA_W-1:0]             i_bus_data,
    input  logic                          i_bus_data_ready
);

    localparam int              WW      = MAX_BEATS * DATA_W;
    // Counter only needs to reach TIMEOUT-1; a 1-bit free-running counter is harmless when TIMEOUT == 0.
    localparam int              CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]   TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK} state_t;

    state_t              r_state, w_state;
    logic                r_busy, w_busy;
    logic                r_done, w_done;
    logic                r_err, w_err;
    logic [WW-1:0]       r_rdata, w_rdata;
    logic                r_bus_clk, w_bus_clk;
    logic                r_bus_we, w_bus_we;
    logic [ADDR_W-1:0]   r_bus_addr, w_bus_addr;
    logic [DATA_W-1:0]   r_bus_data, w_bus_data;
    logic                r_dec, w_dec;
    logic [ADDR_W-1:0]   r_addr, w_addr;
    logic [WW-1:0]       r_wdata, w_wdata;
    logic [BW-1:0]       r_n, w_n;
    logic [BW-1:0]       r_k, w_k;
    logic [CW-1:0]       r_cnt, w_cnt;
    logic                r_to, w_to;

    logic [BW-1:0]       w_req_n;
    logic [BW-1:0]       w_k_inc;
    logic [BW-1:0]       w_idx_acc;
    logic [BW-1:0]       w_idx_cur;
    logic [BW-1:0]       w_idx_nxt;

    // Descending (stack) mode walks the data slices from the top down.
    function automatic logic [BW-1:0] f_slice(input logic dec, input logic [BW-1:0] n,
                                              input logic [BW-1:0] k);
        return dec ? (n - BW'(1) - k) : k;
    endfunction

    function automatic logic [ADDR_W-1:0] f_addr(input logic dec, input logic [ADDR_W-1:0] base,
                                                 input logic [BW-1:0] k);
        return dec ? (base - ADDR_W'(k)) : (base + ADDR_W'(k));
    endfunction

    always_comb begin
        if (i_beats == '0) begin
            w_req_n = BW'(1);
        end else if (i_beats > BW'(MAX_BEATS)) begin
            w_req_n = BW'(MAX_BEATS);
        end else begin
            w_req_n = i_beats;
        end
    end

    assign w_k_inc   = r_k + BW'(1);
    assign w_idx_acc = f_slice(i_dec, w_req_n, '0);
    assign w_idx_cur = f_slice(r_dec, r_n, r_k);
    assign w_idx_nxt = f_slice(r_dec, r_n, w_k_inc);

    always_comb begin
        w_state    = r_state;
        w_busy     = r_busy;
        w_done     = 1'b0;
        w_err      = 1'b0;
        w_rdata    = r_rdata;
        w_bus_clk  = r_bus_clk;
        w_bus_we   = r_bus_we;
        w_bus_addr = r_bus_addr;
        w_bus_data = r_bus_data;
        w_dec      = r_dec;
        w_addr     = r_addr;
        w_wdata    = r_wdata;
        w_n        = r_n;
        w_k        = r_k;
        w_cnt      = r_cnt;
        w_to       = r_to;
        case (r_state)
            S_IDLE: begin
                if (i_req && !r_busy) begin
                    w_dec      = i_dec;
                    w_addr     = i_addr;
                    w_wdata    = i_wdata;
                    w_n        = w_req_n;
                    w_k        = '0;
                    w_cnt      = '0;
                    w_to       = 1'b0;
                    w_rdata    = '0;
                    w_bus_we   = i_we;
                    w_bus_addr = i_addr;
                    w_bus_data = i_wdata[int'(w_idx_acc)*DATA_W +: DATA_W];
                    w_bus_clk  = 1'b1;
                    w_busy     = 1'b1;
                    w_state    = S_REQ;
                end
            end
            S_REQ: begin
                w_cnt = r_cnt + CW'(1);
                if (i_bus_data_ready) begin
                    if (!r_bus_we) begin
                        w_rdata[int'(w_idx_cur)*DATA_W +: DATA_W] = i_bus_data;
                    end
                    w_bus_clk = 1'b0;
                    w_cnt     = '0;
                    w_state   = S_ACK;
                end else if (TIMEOUT != 0 && r_cnt == TO_LAST) begin
                    w_bus_clk = 1'b0;
                    w_to      = 1'b1;
                    w_state   = S_ACK;
                end
            end
            S_ACK: begin
                // Strobe stays low until the slave has released ready (4-phase return to zero).
                if (!i_bus_data_ready) begin
                    if (r_to || r_k == r_n - BW'(1)) begin
                        w_done  = 1'b1;
                        w_err   = r_to;
                        w_busy  = 1'b0;
                        w_state = S_IDLE;
                    end else begin
                        w_k        = w_k_inc;
                        w_bus_addr = f_addr(r_dec, r_addr, w_k_inc);
                        w_bus_data = r_wdata[int'(w_idx_nxt)*DATA_W +: DATA_W];
                        w_bus_clk  = 1'b1;
                        w_cnt      = '0;
                        w_state    = S_REQ;
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
            r_bus_clk  <= 1'b0;
            r_bus_we   <= 1'b0;
            r_bus_addr <= '0;
            r_bus_data <= '0;
            r_dec      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_n        <= '0;
            r_k        <= '0;
            r_cnt      <= '0;
            r_to       <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_err      <= w_err;
            r_rdata    <= w_rdata;
            r_bus_clk  <= w_bus_clk;
            r_bus_we   <= w_bus_we;
            r_bus_addr <= w_bus_addr;
            r_bus_data <= w_bus_data;
            r_dec      <= w_dec;
            r_addr     <= w_addr;
            r_wdata    <= w_wdata;
            r_n        <= w_n;
            r_k        <= w_k;
            r_cnt      <= w_cnt;
            r_to       <= w_to;
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_err      = r_err;
    assign o_rdata    = r_rdata;
    assign o_bus_clk  = r_bus_clk;
    assign o_bus_we   = r_bus_we;
    assign o_bus_addr = r_bus_addr;
    assign o_bus_data = r_bus_data;

endmodule

// File: tb/tb_cpu_bus_seq.sv
module tb_cpu_bus_seq;

    localparam int AW = 32;
    localparam int DW = 8;
    localparam int MB = 4;
    localparam int TO = 8;
    localparam int BW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            req;
    logic            we;
    logic            dec;
    logic [AW-1:0]   addr;
    logic [BW-1:0]   beats;
    logic [31:0]     wdata;
    logic            busy;
    logic            done;
    logic            err;
    logic [31:0]     rdata;
    logic            bus_clk;
    logic            bus_we;
    logic [AW-1:0]   bus_addr;
    logic [DW-1:0]   bus_wdat;
    logic [DW-1:0]   bus_rdat;
    logic            bus_rdy;

    cpu_bus_seq #(.ADDR_W(AW), .DATA_W(DW), .MAX_BEATS(MB), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_dec(dec),
        .i_addr(addr), .i_beats(beats), .i_wdata(wdata),
        .o_busy(busy), .o_done(done), .o_err(err), .o_rdata(rdata),
        .o_bus_clk(bus_clk), .o_bus_we(bus_we), .o_bus_addr(bus_addr),
        .o_bus_data(bus_wdat), .i_bus_data(bus_rdat), .i_bus_data_ready(bus_rdy)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] addr; logic we; logic [7:0] data; int hi; } beat_exp_t;
    typedef struct { logic [31:0] rdata; logic err; longint cyc; } done_exp_t;
    typedef struct { logic [7:0] data; int dhi; int dlo; bit no_ack; } resp_t;

    beat_exp_t beat_q[$];
    done_exp_t done_q[$];
    resp_t     resp_q[$];

    int checks   = 0;
    int failures = 0;
    int rises    = 0;
    bit quiet    = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"},     64'(busy),     64'd0);
        chk({tag, "_done"},     64'(done),     64'd0);
        chk({tag, "_err"},      64'(err),      64'd0);
        chk({tag, "_rdata"},    64'(rdata),    64'd0);
        chk({tag, "_bus_clk"},  64'(bus_clk),  64'd0);
        chk({tag, "_bus_we"},   64'(bus_we),   64'd0);
        chk({tag, "_bus_addr"}, 64'(bus_addr), 64'd0);
        chk({tag, "_bus_data"}, 64'(bus_wdat), 64'd0);
    endtask

    // Reference model: one request expands into its beat list, its responder script and its
    // completion record (read data, error, completion cycle from the handshake delays).
    task automatic send(input bit t_we, input bit t_dec, input logic [31:0] t_addr,
                        input int t_beats, input logic [31:0] t_wdata, input logic [31:0] t_rd,
                        input int dhi, input int dlo, input int to_beat, input bit track);
        int          n;
        int          last;
        int          guard;
        int          j;
        logic [31:0] rexp;
        beat_exp_t   be;
        resp_t       r;
        done_exp_t   de;
        n = (t_beats == 0) ? 1 : ((t_beats > MB) ? MB : t_beats);
        guard = 0;
        while (busy) begin
            tick();
            guard++;
            if (guard > 500) begin
                checks++;
                failures++;
                $display("FAIL send_wait_idle: busy=1 after 500 cycles, required 0");
                return;
            end
        end
        last = (to_beat >= 0) ? to_beat : n - 1;
        rexp = '0;
        for (int k = 0; k <= last; k++) begin
            j = t_dec ? (n - 1 - k) : k;
            r.data   = t_rd[k*8 +: 8];
            r.dhi    = dhi;
            r.dlo    = dlo;
            r.no_ack = (k == to_beat);
            resp_q.push_back(r);
            if (track) begin
                be.addr = t_dec ? (t_addr - 32'(k)) : (t_addr + 32'(k));
                be.we   = t_we;
                be.data = t_wdata[j*8 +: 8];
                be.hi   = (k == to_beat) ? TO : dhi + 1;
                beat_q.push_back(be);
            end
            if (!t_we && k != to_beat) rexp[j*8 +: 8] = t_rd[k*8 +: 8];
        end
        if (track) begin
            de.rdata = rexp;
            de.err   = (to_beat >= 0);
            de.cyc   = cyc + 1 + ((to_beat >= 0) ? longint'(to_beat*(dhi+dlo+2) + TO + 1)
                                                 : longint'(n*(dhi+dlo+2)));
            done_q.push_back(de);
        end
        req   = 1'b1;
        we    = t_we;
        dec   = t_dec;
        addr  = t_addr;
        beats = BW'(t_beats);
        wdata = t_wdata;
        tick();
        req   = 1'b0;
        wdata = $urandom;
        addr  = $urandom;
    endtask

    // Bus slave: raises ready dhi samples after the strobe rises, drops it dlo samples after it falls.
    initial begin
        resp_t r;
        bus_rdy  = 1'b0;
        bus_rdat = '0;
        forever begin
            tick();
            if (bus_clk) begin
                if (resp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL responder_empty: strobe with no scripted beat, required none");
                    while (bus_clk) tick();
                end else begin
                    r = resp_q.pop_front();
                    if (!r.no_ack) begin
                        repeat (r.dhi) tick();
                        bus_rdat = r.data;
                        bus_rdy  = 1'b1;
                    end
                    while (bus_clk) tick();
                    if (!r.no_ack) begin
                        repeat (r.dlo) tick();
                        bus_rdy  = 1'b0;
                        bus_rdat = $urandom;
                    end
                end
            end
        end
    end

    // Beat monitor.
    initial begin
        bit        prev = 1'b0;
        bit        have = 1'b0;
        int        hi   = 0;
        beat_exp_t cur;
        forever begin
            tick();
            if (bus_clk && !prev) begin
                rises++;
                hi = 0;
                if (!quiet) begin
                    if (beat_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat: addr=0x%0h, required no beat", bus_addr);
                    end else begin
                        cur  = beat_q.pop_front();
                        have = 1'b1;
                        chk("beat_addr", 64'(bus_addr), 64'(cur.addr));
                        chk("beat_we",   64'(bus_we),   64'(cur.we));
                        if (cur.we) chk("beat_wdata", 64'(bus_wdat), 64'(cur.data));
                    end
                end
            end
            if (bus_clk) hi++;
            if (!bus_clk && prev && have) begin
                chk("beat_high_cycles", 64'(hi), 64'(cur.hi));
                have = 1'b0;
            end
            if (rst) have = 1'b0;
            prev = bus_clk;
        end
    end

    // Completion monitor.
    initial begin
        done_exp_t de;
        forever begin
            tick();
            if (done) begin
                if (done_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: done=1 err=%0d, required no done", err);
                end else begin
                    de = done_q.pop_front();
                    chk("done_rdata", 64'(rdata), 64'(de.rdata));
                    chk("done_err",   64'(err),   64'(de.err));
                    chk("done_cycle", 64'(cyc),   64'(de.cyc));
                    chk("done_busy",  64'(busy),  64'd0);
                end
            end
        end
    end

    initial begin
        int guard;
        int r0;
        int n;
        int tb;
        logic [31:0] a;
        rst   = 1'b1;
        req   = 1'b0;
        we    = 1'b0;
        dec   = 1'b0;
        addr  = '0;
        beats = '0;
        wdata = '0;
        repeat (3) tick();
        chk_outputs_zero("reset");
        rst = 1'b0;
        tick();

        // Directed scenarios.
        send(1'b0, 1'b0, 32'h0000_1000, 1, 32'h0, 32'h0000_00A5, 2, 1, -1, 1'b1);
        send(1'b1, 1'b0, 32'h0000_2000, 4, 32'h4433_2211, 32'h0, 1, 1, -1, 1'b1);
        send(1'b1, 1'b1, 32'h0000_01FF, 2, 32'h0000_BBAA, 32'h0, 0, 0, -1, 1'b1);
        send(1'b0, 1'b0, 32'hFFFF_FFFF, 2, 32'h0, 32'h0000_3412, 1, 2, -1, 1'b1);
        send(1'b0, 1'b0, 32'h0000_3000, 1, 32'h0, 32'h0000_0077, 0, 0, 0, 1'b1);
        send(1'b0, 1'b0, 32'h0000_3000, 3, 32'h0, 32'h00C3_B2A1, 1, 0, -1, 1'b1);
        send(1'b0, 1'b1, 32'h0000_0001, 4, 32'h0, 32'h4D3C_2B1A, 0, 1, 2, 1'b1);
        send(1'b1, 1'b0, 32'h0000_5000, 0, 32'hDEAD_BEEF, 32'h0, 1, 0, -1, 1'b1);
        send(1'b1, 1'b1, 32'h0000_6000, 7, 32'hDEAD_BEEF, 32'h0, 0, 2, -1, 1'b1);

        // Reset during beat 2 of a 4-beat write: everything clears, no completion.
        guard = 0;
        while (busy && guard < 500) begin tick(); guard++; end
        quiet = 1'b1;
        r0 = rises;
        send(1'b1, 1'b0, 32'h0000_4000, 4, 32'hDDCC_BBAA, 32'h0, 2, 1, -1, 1'b0);
        guard = 0;
        while (rises < r0 + 3 && guard < 200) begin tick(); guard++; end
        if (guard >= 200) begin
            checks++;
            failures++;
            $display("FAIL reset_reach_beat2: beats seen=%0d, required 3", rises - r0);
        end
        rst = 1'b1;
        tick();
        chk_outputs_zero("midreset");
        rst = 1'b0;
        repeat (12) tick();
        resp_q.delete();
        quiet = 1'b0;

        // Randomised traffic.
        for (int i = 0; i < 40; i++) begin
            tb = int'($urandom_range(0, 7));
            n  = (tb == 0) ? 1 : ((tb > MB) ? MB : tb);
            a  = $urandom;
            if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 1) ? 32'hFFFF_FFFE : 32'h0000_0001;
            send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, tb, $urandom, $urandom,
                 int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, n - 1)) : -1, 1'b1);
        end

        guard = 0;
        while (done_q.size() != 0 && guard < 3000) begin tick(); guard++; end
        if (done_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_done: %0d completions outstanding, required 0", done_q.size());
        end
        repeat (4) tick();
        chk("drain_beats", 64'(beat_q.size()), 64'd0);
        chk("drain_resp",  64'(resp_q.size()), 64'd0);
        chk("end_idle",    64'(busy),          64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
